// File: rtl/twid_descale.sv
// -----------------------------------------------------------------------------
// twid_descale
//
// Output-side requantizer for the merged DIT radix-4 butterfly. Removes the
// 2^SHIFT twiddle gain from wide complex products with round-half-up, then
// saturates to OUT_WIDTH. The stages are:
//   S1 registers the input,
//   S2 rounds and shifts,
//   S3 clamps and drives the outputs.
// All three stages move together under a single global enable. A sticky
// 16-bit counter tracks how many saturated samples were taken downstream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_r, in_i            signed IN_W-bit product, real / imaginary
//   out_valid / out_ready output handshake
//   out_r, out_i          signed OUT_WIDTH-bit rounded, saturated result
//   out_sat               either component of the presented sample clamped
//   sat_count             saturated samples accepted downstream (sticky max)
//   clr_count             synchronous clear of sat_count (wins over increment)
// -----------------------------------------------------------------------------
module twid_descale #(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int OUT_WIDTH  = 22,
  localparam int IN_W      = DATA_WIDTH + TWID_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_W-1:0]      in_r,
  input  logic signed [IN_W-1:0]      in_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_r,
  output logic signed [OUT_WIDTH-1:0] out_i,
  output logic                        out_sat,
  output logic [15:0]                 sat_count,
  input  logic                        clr_count
);

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  localparam int SUM_W = IN_W + 1;
  localparam int SH_W  = SUM_W - SHIFT;
  localparam int CW    = (SH_W > OUT_WIDTH) ? SH_W : OUT_WIDTH;

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [CW-1:0]    MAX_C = CW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [CW-1:0]    MIN_C = CW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef struct packed {
    logic                 sat;
    logic [OUT_WIDTH-1:0] val;
  } clamp_t;

  // Round half-up: add 2^(SHIFT-1), then floor via arithmetic shift.
  // For example, -3.5 becomes -3.
  function automatic logic signed [SH_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [SUM_W-1:0] s;
    s = $signed({x[IN_W-1], x}) + RND;
    s = s >>> SHIFT;
    return s[SH_W-1:0];
  endfunction

  function automatic clamp_t clamp(input logic signed [SH_W-1:0] v);
    logic signed [CW-1:0] w;
    clamp_t               c;
    w     = CW'(v);
    c.sat = 1'b0;
    c.val = w[OUT_WIDTH-1:0];
    if (w > MAX_C) begin
      c.sat = 1'b1;
      c.val = MAX_C[OUT_WIDTH-1:0];
    end else if (w < MIN_C) begin
      c.sat = 1'b1;
      c.val = MIN_C[OUT_WIDTH-1:0];
    end
    return c;
  endfunction

  // Stage registers
  logic                        v1_q, v1_d;
  logic signed [IN_W-1:0]      r1_q, r1_d, i1_q, i1_d;
  logic                        v2_q, v2_d;
  logic signed [SH_W-1:0]      r2_q, r2_d, i2_q, i2_d;
  logic                        v3_q, v3_d;
  logic signed [OUT_WIDTH-1:0] r3_q, r3_d, i3_q, i3_d;
  logic                        sat3_q, sat3_d;
  logic [15:0]                 cnt_q, cnt_d;

  logic   en;
  clamp_t c_r, c_i;

  // A single enable keeps the stages in lockstep. A stall freezes the whole
  // pipe, so the output stays stable and nothing is dropped.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  assign c_r = clamp(r2_q);
  assign c_i = clamp(i2_q);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    v1_d   = v1_q;
    r1_d   = r1_q;
    i1_d   = i1_q;
    v2_d   = v2_q;
    r2_d   = r2_q;
    i2_d   = i2_q;
    v3_d   = v3_q;
    r3_d   = r3_q;
    i3_d   = i3_q;
    sat3_d = sat3_q;
    if (en) begin
      v1_d   = in_valid;
      r1_d   = in_r;
      i1_d   = in_i;
      v2_d   = v1_q;
      r2_d   = round_shift(r1_q);
      i2_d   = round_shift(i1_q);
      v3_d   = v2_q;
      r3_d   = $signed(c_r.val);
      i3_d   = $signed(c_i.val);
      sat3_d = c_r.sat | c_i.sat;
    end
  end

  // Count whole samples, not components. The count sticks at all-ones, and a
  // clear takes priority over a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (v3_q && out_ready && sat3_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  // NOTE: the data registers are reset as well as the valids, so the outputs
  // read zero straight out of reset instead of stale or X data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      i1_q   <= '0;
      v2_q   <= 1'b0;
      r2_q   <= '0;
      i2_q   <= '0;
      v3_q   <= 1'b0;
      r3_q   <= '0;
      i3_q   <= '0;
      sat3_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      r1_q   <= r1_d;
      i1_q   <= i1_d;
      v2_q   <= v2_d;
      r2_q   <= r2_d;
      i2_q   <= i2_d;
      v3_q   <= v3_d;
      r3_q   <= r3_d;
      i3_q   <= i3_d;
      sat3_q <= sat3_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = v3_q;
  assign out_r     = r3_q;
  assign out_i     = i3_q;
  assign out_sat   = sat3_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_twid_descale.sv
// -----------------------------------------------------------------------------
// Self-checking bench for twid_descale (default parameters).
//
// A reference model computes the expected result of every accepted input from
// the arithmetic rules: floor((x + 2^14) / 2^15), then clamp to 22 bits. The
// expected results sit in an in-order queue. A monitor on the falling edge
// checks each output handshake against that queue. It also checks that the
// outputs hold while stalled, and checks sat_count against a model counter.
// Directed cases add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_twid_descale;

  localparam int  IN_W   = 38;
  localparam int  OUT_W  = 22;
  localparam longint OMAX = 2097151;
  localparam longint OMIN = -2097152;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_r, in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_r, out_i;
  logic                    out_sat;
  logic [15:0]             sat_count;
  logic                    clr_count;

  twid_descale dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint r;
    longint i;
    bit     sat;
  } exp_t;

  function automatic longint rq(input longint v);
    longint n, q;
    n = v + 16384;
    q = n / 32768;                       // truncates toward zero
    if ((n % 32768 != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input longint r, input longint i);
    exp_t   e;
    longint qr, qi;
    qr    = rq(r);
    qi    = rq(i);
    e.sat = 1'b0;
    if (qr > OMAX) begin qr = OMAX; e.sat = 1'b1; end
    if (qr < OMIN) begin qr = OMIN; e.sat = 1'b1; end
    if (qi > OMAX) begin qi = OMAX; e.sat = 1'b1; end
    if (qi < OMIN) begin qi = OMIN; e.sat = 1'b1; end
    e.r = qr;
    e.i = qi;
    return e;
  endfunction

  // ---------------- out_ready driver ----------------
  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t   exp_q[$];
  longint mcnt = 0;
  bit     hold = 1'b0;
  longint h_r, h_i, h_s;

  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    if (!rst_n) begin
      exp_q.delete();
      mcnt = 0;
      hold = 1'b0;
    end else begin
      check("sat_count", longint'(sat_count), mcnt);
      if (hold) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_r", longint'(out_r), h_r);
        check("stall_i", longint'(out_i), h_i);
        check("stall_sat", longint'(out_sat), h_s);
      end
      hs    = out_valid && out_ready;
      e.sat = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("out_without_input", longint'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("out_r", longint'(out_r), e.r);
          check("out_i", longint'(out_i), e.i);
          check("out_sat", longint'(out_sat), longint'(e.sat));
        end
      end
      if (clr_count) mcnt = 0;
      else if (hs && e.sat && mcnt != 65535) mcnt = mcnt + 1;
      hold = out_valid && !out_ready;
      h_r  = longint'(out_r);
      h_i  = longint'(out_i);
      h_s  = longint'(out_sat);
      if (in_valid && in_ready) exp_q.push_back(model(longint'(in_r), longint'(in_i)));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1. Returns at posedge+1 right after the accepting edge.
  task automatic send(input longint r, input longint i);
    bit acc;
    int tries;
    in_valid = 1'b1;
    in_r     = IN_W'(r);
    in_i     = IN_W'(i);
    acc      = 1'b0;
    tries    = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check("accept_timeout", longint'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presented in cycle 0: out_valid must be low after the second edge and
  // high after the third edge.
  task automatic run_one(input string name, input longint r, input longint i,
                         input longint er, input longint ei, input longint es);
    send(r, i);
    @(posedge clk); #1;
    check({name, "_early"}, longint'(out_valid), 0);
    @(posedge clk); #1;
    check({name, "_valid"}, longint'(out_valid), 1);
    check({name, "_r"}, longint'(out_r), er);
    check({name, "_i"}, longint'(out_i), ei);
    check({name, "_sat"}, longint'(out_sat), es);
    idle(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] raw;
    longint      vr, vi;
    int          tries;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_r      = '0;
    in_i      = '0;
    clr_count = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_r", longint'(out_r), 0);
    check("rst_out_i", longint'(out_i), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // Pin the reference model with hand-computed values.
    check("model_3", rq(98304), 3);
    check("model_3p5", rq(114688), 4);
    check("model_m3p5", rq(-114688), -3);
    check("model_m3p5p", rq(-114689), -4);
    check("model_16383", rq(16383), 0);

    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", longint'(in_ready), 1);

    // Exact and rounding cases
    run_one("exact3", 98304, 16383, 3, 0, 0);
    run_one("half_up", 114688, 16384, 4, 1, 0);
    run_one("neg_half", -114688, -16385, -3, -1, 0);

    // Saturation cases
    run_one("sat_pos", 64'sd1 <<< 36, 0, OMAX, 0, 1);
    run_one("sat_neg", 0, -(64'sd1 <<< 37), 0, OMIN, 1);
    run_one("sat_guard", (64'sd1 <<< 37) - 1, 5, OMAX, 0, 1);

    // A sample that clamps on both components counts once.
    clr_count = 1'b1; idle(1); clr_count = 1'b0;
    check("clr_before_both", longint'(sat_count), 0);
    run_one("sat_both", 64'sd1 <<< 36, -(64'sd1 <<< 37), OMAX, OMIN, 1);
    idle(1);
    check("count_once", longint'(sat_count), 1);

    // Streaming under random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      raw = {$urandom, $urandom};
      vr  = longint'($signed(raw[37:0])) >>> (k % 20);
      raw = {$urandom, $urandom};
      vi  = longint'($signed(raw[37:0])) >>> ((k * 7) % 20);
      if (k % 8 == 3) vr = (k - 32) * 32768 + 16384;   // exact .5 points
      send(vr, vi);
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    tries = 0;
    while (exp_q.size() != 0 && tries < 50) begin
      idle(1);
      tries++;
    end
    check("stream_drained", longint'(exp_q.size()), 0);

    // Counter preload to 0xFFFE, then check the sticky maximum.
    clr_count = 1'b1; idle(1); clr_count = 1'b0;
    for (int k = 0; k < 65534; k++) send(64'sd1 <<< 36, 0);
    idle(5);
    check("cnt_fffe", longint'(sat_count), 65534);
    send(64'sd1 <<< 36, 0);
    idle(5);
    check("cnt_ffff", longint'(sat_count), 65535);
    send(64'sd1 <<< 36, 0);
    send(0, -(64'sd1 <<< 37));
    idle(5);
    check("cnt_hold", longint'(sat_count), 65535);

    // A clear in the same cycle as a saturating handshake yields zero.
    send(64'sd1 <<< 36, 0);
    tries = 0;
    while (!out_valid && tries < 10) begin
      idle(1);
      tries++;
    end
    check("clr_wait_valid", longint'(out_valid), 1);
    clr_count = 1'b1;
    idle(1);
    clr_count = 1'b0;
    check("clr_priority", longint'(sat_count), 0);
    idle(3);

    // Reset with three samples in flight
    send(98304, 0);
    send(114688, 0);
    send(-114688, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_r", longint'(out_r), 0);
    check("mid_rst_i", longint'(out_i), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("no_stale", longint'(out_valid), 0);
    end
    run_one("after_rst", 327680, -98304, 10, -3, 0);
    idle(3);
    check("final_drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
